// File: rtl/ll_walker_if.sv
// ll_walker_if: head-pointer input, link-write port and walk outputs of ll_walker
interface ll_walker_if #(parameter int W_PTR = 8);
  logic [W_PTR-1:0] in_ptr, link_addr, link_data, out_ptr;
  logic in_ptr_vld, link_we, out_ptr_vld, out_last, busy, overflow, loop_err;
  modport master (
    output in_ptr, in_ptr_vld, link_we, link_addr, link_data,
    input  out_ptr, out_ptr_vld, out_last, busy, overflow, loop_err
  );
  modport slave (
    input  in_ptr, in_ptr_vld, link_we, link_addr, link_data,
    output out_ptr, out_ptr_vld, out_last, busy, overflow, loop_err
  );
endinterface

// File: rtl/ll_walker.sv
// ll_walker: buffers head pointers and walks each linked list through a next-pointer table
module ll_walker #(
  parameter int N = 256,
  parameter int W_PTR = $clog2(N),
  parameter logic [W_PTR-1:0] NIL = W_PTR'(N - 1),
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_HOPS = N
) (
  input logic clk,
  input logic rst,
  ll_walker_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(MAX_HOPS + 1);
  typedef enum logic {IDLE, WALK} state_t;
  state_t state_q, state_d;
  logic [W_PTR-1:0] tbl_q [N];
  logic [W_PTR-1:0] tbl_d [N];
  logic [W_PTR-1:0] fifo_q [FIFO_DEPTH];
  logic [W_PTR-1:0] fifo_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [W_PTR-1:0] cur_q, cur_d, out_ptr_q, out_ptr_d, head, nxt;
  logic [HW-1:0] hop_q, hop_d;
  logic out_ptr_vld_q, out_ptr_vld_d, out_last_q, out_last_d;
  logic overflow_q, overflow_d, loop_err_q, loop_err_d;
  logic pop, push, hop_lim;
  always_comb begin
    head = fifo_q[rd_q];
    nxt = tbl_q[cur_q];
    pop = state_q == IDLE && cnt_q != '0;
    // a full FIFO still accepts when the same cycle frees a slot
    push = bus.in_ptr_vld && (cnt_q != (AW+1)'(FIFO_DEPTH) || pop);
    tbl_d = tbl_q;
    if (bus.link_we) tbl_d[bus.link_addr] = bus.link_data;
    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = bus.in_ptr;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = overflow_q | (bus.in_ptr_vld & ~push);
    state_d = state_q;
    cur_d = cur_q;
    hop_d = hop_q;
    hop_lim = 1'b0;
    out_ptr_d = out_ptr_q;
    out_ptr_vld_d = 1'b0;
    out_last_d = 1'b0;
    loop_err_d = loop_err_q;
    if (state_q == IDLE) begin
      cur_d = pop ? head : cur_q;
      hop_d = pop && head != NIL ? '0 : hop_q;
      state_d = pop && head != NIL ? WALK : IDLE;
    end else begin
      hop_d = hop_q + 1'b1;
      hop_lim = hop_d == HW'(MAX_HOPS);
      out_ptr_d = cur_q;
      out_ptr_vld_d = 1'b1;
      out_last_d = nxt == NIL || hop_lim;
      loop_err_d = loop_err_q | (nxt != NIL && hop_lim);
      state_d = out_last_d ? IDLE : WALK;
      cur_d = out_last_d ? cur_q : nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tbl_q <= '{default: NIL};
      fifo_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      cur_q <= '0;
      hop_q <= '0;
      out_ptr_q <= '0;
      out_ptr_vld_q <= 1'b0;
      out_last_q <= 1'b0;
      overflow_q <= 1'b0;
      loop_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q <= tbl_d;
      fifo_q <= fifo_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      hop_q <= hop_d;
      out_ptr_q <= out_ptr_d;
      out_ptr_vld_q <= out_ptr_vld_d;
      out_last_q <= out_last_d;
      overflow_q <= overflow_d;
      loop_err_q <= loop_err_d;
    end
  end
  assign bus.out_ptr = out_ptr_q;
  assign bus.out_ptr_vld = out_ptr_vld_q;
  assign bus.out_last = out_last_q;
  assign bus.overflow = overflow_q;
  assign bus.loop_err = loop_err_q;
  assign bus.busy = state_q != IDLE || cnt_q != '0;
endmodule

// File: tb/tb_ll_walker.sv
// tb_ll_walker: two walkers (MAX_HOPS 256 and 5) on shared stimulus, each against a queue-based model
module tb_ll_walker;
  logic clk, rst, in_ptr_vld, link_we, chk_en;
  logic [7:0] in_ptr, link_addr, link_data;
  int checks, failures;
  localparam logic [7:0] NIL = 8'hFF;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int MH = (g == 0) ? 256 : 5;
    ll_walker_if #(.W_PTR(8)) bus ();
    ll_walker #(.MAX_HOPS(MH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    assign bus.in_ptr = in_ptr;
    assign bus.in_ptr_vld = in_ptr_vld;
    assign bus.link_we = link_we;
    assign bus.link_addr = link_addr;
    assign bus.link_data = link_data;
    logic [7:0] tbl [256];
    logic [7:0] hq [$];
    logic [9:0] pq [$];
    logic [9:0] e;
    logic [7:0] h, cur, nx, m_ptr;
    bit m_vld, m_last, m_ovf, m_lerr, m_busy, quiet, idle;
    // pq holds the nodes still to be emitted for the current list as {trunc, last, ptr}
    always @(posedge clk) begin
      if (rst) begin
        hq.delete();
        pq.delete();
        for (int i = 0; i < 256; i++) tbl[i] = NIL;
        {m_ptr, m_vld, m_last, m_ovf, m_lerr, m_busy} = '0;
        quiet = 1'b1;
      end else begin
        idle = pq.size() == 0;
        if (link_we) tbl[link_addr] = link_data;
        m_vld = 1'b0;
        m_last = 1'b0;
        if (!idle) begin
          e = pq.pop_front();
          m_vld = 1'b1;
          m_ptr = e[7:0];
          m_last = e[8];
          if (e[9]) m_lerr = 1'b1;
        end else if (hq.size() != 0) begin
          h = hq.pop_front();
          if (h != NIL) begin
            cur = h;
            for (int n = 1; n <= MH; n++) begin
              nx = tbl[cur];
              if (nx == NIL) begin pq.push_back({2'b01, cur}); break; end
              if (n == MH) begin pq.push_back({2'b11, cur}); break; end
              pq.push_back({2'b00, cur});
              cur = nx;
            end
          end
        end
        if (in_ptr_vld) begin
          if (hq.size() < 4) hq.push_back(in_ptr);
          else m_ovf = 1'b1;
        end
        m_busy = pq.size() != 0 || hq.size() != 0;
        quiet = pq.size() == 0;
      end
    end
    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("l%0d_vld", g), 32'(bus.out_ptr_vld), 32'(m_vld));
        check($sformatf("l%0d_last", g), 32'(bus.out_last), 32'(m_last));
        check($sformatf("l%0d_ptr", g), 32'(bus.out_ptr), 32'(m_ptr));
        check($sformatf("l%0d_busy", g), 32'(bus.busy), 32'(m_busy));
        check($sformatf("l%0d_ovf", g), 32'(bus.overflow), 32'(m_ovf));
        check($sformatf("l%0d_lerr", g), 32'(bus.loop_err), 32'(m_lerr));
      end
    end
  end
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    link_we = 1'b1;
    link_addr = a;
    link_data = d;
    @(negedge clk);
    link_we = 1'b0;
  endtask
  task automatic push(input logic [7:0] p);
    in_ptr = p;
    in_ptr_vld = 1'b1;
    @(negedge clk);
    in_ptr_vld = 1'b0;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    while ((lane[0].bus.busy || lane[1].bus.busy) && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 32'(k < lim), 32'd1);
    @(negedge clk);
  endtask
  initial begin
    logic [7:0] heads [8] = '{8'd3, 8'd5, 8'd3, 8'd5, 8'd20, 8'd21, 8'd22, 8'd23};
    checks = 0;
    failures = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    {in_ptr, in_ptr_vld, link_we, link_addr, link_data} = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_vld", 32'(lane[0].bus.out_ptr_vld), 32'd0);
    check("rst_busy", 32'(lane[0].bus.busy), 32'd0);
    rst = 1'b0;
    wr(8'd3, 8'd7);
    wr(8'd7, 8'd2);
    wr(8'd2, NIL);
    push(8'd3);
    wait_idle(20);
    wr(8'd5, NIL);
    push(8'd3);
    push(8'd5);
    wait_idle(20);
    check("no_ovf", 32'(lane[0].bus.overflow), 32'd0);
    for (int i = 10; i < 40; i++) wr(8'(i), 8'(i + 1));
    wr(8'd40, NIL);
    push(8'd10);
    for (int i = 0; i < 8; i++) begin
      in_ptr = heads[i];
      in_ptr_vld = 1'b1;
      @(negedge clk);
    end
    in_ptr_vld = 1'b0;
    wait_idle(300);
    check("ovf_set", 32'(lane[0].bus.overflow), 32'd1);
    check("lerr_long_256", 32'(lane[0].bus.loop_err), 32'd0);
    pulse_rst();
    check("ovf_clr", 32'(lane[0].bus.overflow), 32'd0);
    wr(8'd1, 8'd4);
    wr(8'd4, 8'd1);
    push(8'd1);
    wait_idle(600);
    check("lerr_5", 32'(lane[1].bus.loop_err), 32'd1);
    check("lerr_256", 32'(lane[0].bus.loop_err), 32'd1);
    push(NIL);
    wait_idle(10);
    pulse_rst();
    wr(8'd3, 8'd7);
    wr(8'd7, 8'd2);
    wr(8'd2, NIL);
    push(8'd3);
    repeat (2) @(negedge clk);
    check("mid_first", 32'(lane[0].bus.out_ptr), 32'd3);
    pulse_rst();
    check("mid_vld", 32'(lane[0].bus.out_ptr_vld), 32'd0);
    check("mid_ptr", 32'(lane[0].bus.out_ptr), 32'd0);
    check("mid_busy", 32'(lane[0].bus.busy), 32'd0);
    push(8'd3);
    wait_idle(20);
    for (int i = 0; i < 16; i++) wr(8'(i), ($urandom % 3 == 0) ? NIL : 8'($urandom % 16));
    repeat (3000) begin
      link_we = lane[0].quiet && lane[1].quiet && ($urandom % 4 == 0);
      link_addr = 8'($urandom % 16);
      link_data = ($urandom % 3 == 0) ? NIL : 8'($urandom % 16);
      in_ptr_vld = $urandom % 4 == 0;
      in_ptr = ($urandom % 5 == 0) ? NIL : 8'($urandom % 16);
      @(negedge clk);
    end
    {in_ptr_vld, link_we} = '0;
    wait_idle(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
